// File: rtl/uart_rx_mv_sampler.sv
// Majority-vote bit sampler for the UART receive path.
// Captures an odd number of samples centred on each bit period, votes on them
// and emits the voted bit with a one-cycle strobe, plus noise and
// prescale-configuration flags. An optional rx_in synchroniser feeds the samples.
module uart_rx_mv_sampler #(
    parameter int NUM_SAMPLES = 3,
    parameter int PRESCALE_W  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  data_sample_en,
    input  logic                  rx_in,
    output logic                  rx_sync,
    output logic                  sampled_data,
    output logic                  sampled_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int HALF  = (NUM_SAMPLES - 1) / 2;
    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [PRESCALE_W:0] HALF_W       = (PRESCALE_W + 1)'(HALF);
    localparam logic [PRESCALE_W:0] MIN_PRESCALE = (PRESCALE_W + 1)'(NUM_SAMPLES + 2);
    localparam logic [IDX_W-1:0]    IDX_LAST     = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0]    HALF_C       = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]    ALL_C        = CNT_W'(NUM_SAMPLES);

    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_SAMPLES-1:0] samples_q, samples_d;
    logic [NUM_SAMPLES-1:0] shifted;
    logic [CNT_W-1:0]       ones;
    logic                   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   noise_q, noise_d;
    logic                   cfg_q;

    logic [PRESCALE_W:0]    prescale_ext;
    logic [PRESCALE_W:0]    centre;
    logic [PRESCALE_W:0]    win_start;
    logic [PRESCALE_W:0]    target;
    logic                   window_hit;
    logic                   boundary_abort;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign rx_sync = rx_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the raw line through the synchroniser chain; idle-high after reset
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= rx_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign rx_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Window position arithmetic is one bit wider than prescale so the sum never wraps
    assign prescale_ext   = {1'b0, prescale};
    assign centre         = prescale_ext >> 1;
    assign win_start      = centre - HALF_W;
    assign target         = win_start + (PRESCALE_W + 1)'(idx_q);
    assign window_hit     = ({1'b0, edge_cnt} == target);
    assign boundary_abort = (edge_cnt == '0) && (idx_q != '0);

    // Candidate sample register with the current line value shifted in, and its ones count
    always_comb begin
        shifted    = samples_q;
        shifted[0] = rx_sync;
        for (int i = 1; i < NUM_SAMPLES; i++) begin
            shifted[i] = samples_q[i-1];
        end
        ones = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            ones = ones + CNT_W'(shifted[i]);
        end
    end

    // Capture, abort and vote decisions; aborts take priority over a window hit
    always_comb begin
        idx_d     = idx_q;
        samples_d = samples_q;
        data_d    = data_q;
        noise_d   = noise_q;
        valid_d   = 1'b0;
        if (!data_sample_en || cfg_q || boundary_abort) begin
            idx_d = '0;
        end else if (window_hit) begin
            samples_d = shifted;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                valid_d = 1'b1;
                data_d  = (ones > HALF_C);
                noise_d = (ones != '0) && (ones != ALL_C);
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Sampler state and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q     <= '0;
            samples_q <= '1;
            data_q    <= 1'b1;
            valid_q   <= 1'b0;
            noise_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            samples_q <= samples_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            noise_q   <= noise_d;
        end
    end

    // Flag a prescale too small to hold the window plus a margin on each side
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg_q <= 1'b0;
        end else begin
            cfg_q <= (prescale_ext < MIN_PRESCALE);
        end
    end

    assign sampled_data  = data_q;
    assign sampled_valid = valid_q;
    assign noise_err     = noise_q;
    assign cfg_err       = cfg_q;

endmodule

// File: doc/uart_rx_mv_sampler.md
Name: uart_rx_mv_sampler

Overview:
Parametrised majority-vote bit sampler for the UART receive path, and the successor to the fixed 3-sample data sampler. It takes a configurable odd number of samples centred on each bit period and emits the voted bit with a one-cycle valid strobe. It also flags noisy bits and bad prescale configurations. It sits between the RX edge/bit counter and the RX FSM, parity/stop checkers and deserializer. An optional input synchroniser is included.

Parameters:
NUM_SAMPLES, 3, odd sample count per bit; legal values 1, 3, 5, 7.
PRESCALE_W, 6, width of prescale and edge_cnt.
SYNC_STAGES, 2, flops in the rx_in synchroniser; legal values 0 to 3; 0 means bypass.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST  in  1  asynchronous, active-high reset.
prescale  in  PRESCALE_W  oversampling ratio (clocks per bit); quasi-static.
edge_cnt  in  PRESCALE_W  clock index within the current bit, 0 to prescale-1, from the edge counter.
data_sample_en  in  1  sampling enable from the RX FSM.
rx_in  in  1  raw serial line.
rx_sync  out  1  synchronised line; start-bit detection upstream uses this so its timing aligns with the samples.
sampled_data  out  1  registered majority-voted bit.
sampled_valid  out  1  one-cycle strobe; sampled_data is new this cycle.
noise_err  out  1  registered; valid with sampled_valid; 1 if the samples in the window were not all equal.
cfg_err  out  1  registered; 1 when prescale < NUM_SAMPLES+2.

Behaviour:
- Reset (RST=1, asynchronous) sets:
  - synchroniser flops to 1;
  - sampled_data to 1 (idle line);
  - sampled_valid, noise_err and cfg_err to 0;
  - sample index to 0 and sample register to all 1s.
- Synchroniser: rx_sync is rx_in delayed by SYNC_STAGES flops; with SYNC_STAGES=0, rx_sync = rx_in combinationally.
- Window arithmetic, computed at PRESCALE_W+1 bits with no underflow:
  - HALF = (NUM_SAMPLES-1)/2;
  - centre = floor(prescale/2);
  - start = centre - HALF;
  - last = centre + HALF.
- Capture rule:
  - A sample index idx runs from 0 to NUM_SAMPLES-1.
  - On a clock with data_sample_en=1, cfg_err=0 and edge_cnt == start+idx: rx_sync is shifted into the sample register and idx increments.
- Completion: on the capture where idx == NUM_SAMPLES-1:
  - idx returns to 0;
  - on the next clock, sampled_valid=1 for exactly one cycle;
  - sampled_data becomes the majority of the NUM_SAMPLES samples (ones count > HALF);
  - noise_err = (ones count not equal to 0 and not equal to NUM_SAMPLES).
- Latency: sampled_valid is asserted in the cycle after edge_cnt == last.
- Outputs held between strobes: sampled_data and noise_err keep their values until the next valid.
- Abort conditions, each clears idx to 0 with no valid that bit:
  - data_sample_en=0 on any clock;
  - edge_cnt == 0 while idx != 0 (bit boundary reached mid-window).
  - An edge_cnt that skips a window position stalls idx, so no valid is produced; the next edge_cnt=0 then clears idx.
- Simultaneous events: if edge_cnt == 0 and edge_cnt == start+idx on the same clock, the clear wins. This can only happen with an illegal config, so it is covered by cfg_err.
- cfg_err:
  - registered every clock from prescale;
  - while it is 1, no captures and no valid;
  - idx is held at 0.
- Reset mid-window: everything returns to reset values immediately; sampling resumes on the next complete window after RST falls.
- NUM_SAMPLES=1: single sample at centre; noise_err is always 0.

Test Plan:
1. NUM_SAMPLES=3, prescale=8, edge_cnt 0 to 7, rx_sync=1 at cnt 3/4/5 -> sampled_valid=1 in the cycle after cnt=5; sampled_data=1; noise_err=0.
2. Same config, rx_sync values 0,1,0 at cnt 3/4/5 -> sampled_data=0, noise_err=1. Then 1,1,0 -> sampled_data=1, noise_err=1.
3. NUM_SAMPLES=5, prescale=16, samples at cnt 6 to 10 with pattern 1,0,0,1,0 -> valid after cnt=10; sampled_data=0; noise_err=1. Exactly one valid per bit over 10 consecutive bits.
4. Drop data_sample_en at cnt=4 (NUM_SAMPLES=3, prescale=8) -> no sampled_valid that bit; the next bit with enable high gives a normal valid. Separately, assert RST mid-window -> outputs read 1/0/0/0 immediately.
5. NUM_SAMPLES=5, prescale=6 -> cfg_err=1 one clock later; no valid over 20 bits. Change prescale to 7 -> cfg_err=0; the valid strobe returns.
6. SYNC_STAGES=2, toggle rx_in -> rx_sync follows 2 clocks later. SYNC_STAGES=0 -> rx_sync equals rx_in in the same cycle; scenarios 1 and 2 pass in both configurations.
